truth_table_probe: RTL and testbench
====================================

# truth_table_probe

Sequential characterizer for a 3-input, 1-output logic circuit. It drives all eight input combinations into the device under test in order and samples the single output for each. It then assembles an 8-bit truth-table word in the same hex convention the 3-input gate modules are named by (for example, 0x5B) and compares it against an expected word. The probe sits on the bench/top side of a gate module: its `probe_in` drives the gate's `{in1, in2, in3}` and its `probe_out` reads the gate's `out`.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 4: cycles each input vector is held before sampling. Legal range 1..255.

Ports:
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  pulse to begin a characterization run; accepted only in IDLE.
- `expected`  input  8  reference truth-table word; sampled in the DONE state.
- `probe_out`  input  1  output of the device under test.
- `probe_in`  output  3  drive to the device under test: `probe_in[2]`=in1, `probe_in[1]`=in2, `probe_in[0]`=in3.
- `busy`  output  1  high while a run is in progress (DRIVE, SAMPLE, DONE).
- `done`  output  1  one-cycle pulse when `table_out` and `match` update.
- `table_out`  output  8  last captured truth table.
- `match`  output  1  `table_out == expected` at the last completion.

## Operation

- Reset values: `probe_in`=0, `busy`=0, `done`=0, `table_out`=0x00, `match`=0. Internal state: FSM=IDLE, vector index `idx`=0, settle counter=0, shift register=0.
- Bit convention: `table_out[7-idx]` = DUT output for input vector `idx`, where `idx`={in1,in2,in3}. Vector 000 maps to the MSB and vector 111 to the LSB.
- FSM states:
  - IDLE:
    - `start`=1 → DRIVE, with `idx`=0, `probe_in`=000, counter=0.
    - Otherwise stay in IDLE.
  - DRIVE:
    - `probe_in`=`idx`; the counter increments each cycle.
    - When counter==`SETTLE_CYCLES`-1 → SAMPLE.
  - SAMPLE:
    - Capture the sampled DUT output into bit `7-idx` of the internal shift register.
    - If `idx`==7 → DONE.
    - Otherwise `idx`+1, counter=0 → DRIVE.
    - `probe_in` changes to the next vector on the SAMPLE→DRIVE transition.
  - DONE:
    - Load `table_out` from the shift register.
    - Register `match` = (captured word == `expected`).
    - Assert `done` for exactly this cycle, then → IDLE.
- `probe_in` holds its last vector (111) in IDLE after a run.
- `start` is ignored while `busy`=1. It is not queued.
- `table_out` and `match` hold their values until the next DONE or reset.
- Reset mid-run aborts immediately:
  - All outputs return to reset values on the next edge.
  - `done` is not pulsed.
  - The partial result is discarded.
- If `rst` and `start` are high in the same cycle, reset wins.

## Timing

- `start` is sampled at edge 0.
- `busy` rises at edge 1.
- Each vector occupies `SETTLE_CYCLES` DRIVE cycles plus 1 SAMPLE cycle.
- `done` is high in cycle 8×(`SETTLE_CYCLES`+1)+1 after the `start` edge. With the default of 4, that is cycle 41.
- `busy` falls the cycle after `done`.
- A new `start` is accepted in the cycle immediately after `done`, so back-to-back runs have one IDLE cycle between them.
- The sampled value is `probe_out` as registered at the SAMPLE edge. The DUT must therefore settle within `SETTLE_CYCLES` cycles of a `probe_in` change.

## Configuration

- `TRUTH_PROBE_SYNC_EN`
  - Defined:
    - `probe_out` passes through a two-flop synchronizer before sampling, for asynchronous or biological-model DUTs.
    - DRIVE length becomes `SETTLE_CYCLES`+2 cycles per vector.
    - `done` moves to cycle 8×(`SETTLE_CYCLES`+3)+1, which is 57 with the default.
    - The synchronizer flops reset to 0.
  - Undefined: `probe_out` is sampled directly with the timing above.

## Test plan

- DUT model implementing 0x5B (outputs for 000..111 = 0,1,0,1,1,0,1,1), `expected`=0x5B, `SETTLE_CYCLES`=4, pulse `start` → `probe_in` steps 0..7, `done` in cycle 41, `table_out`=0x5B, `match`=1, `busy` low in cycle 42.
- DUT tied to 0, `expected`=0x5B → `table_out`=0x00, `match`=0. Then DUT tied to 1 with `expected`=0xFF → `table_out`=0xFF, `match`=1.
- Start a 0x5B run and assert `rst` at cycle 20 → next cycle `busy`=0, `probe_in`=0, `table_out`=0x00; `done` never pulses. A subsequent `start` completes normally with 0x5B.
- Pulse `start` again at cycles 5 and 30 during a run → ignored; a single `done` at cycle 41. A `start` in cycle 42 → second `done` at cycle 83.
- DUT that changes its output 3 cycles after an input change, `SETTLE_CYCLES`=4 → correct 0x5B. With `SETTLE_CYCLES`=2 → captured word is the table delayed by one vector, with the MSB = the previous run's last value, and `match`=0.
- With `TRUTH_PROBE_SYNC_EN` defined and 0x5B DUT, `SETTLE_CYCLES`=4 → `done` in cycle 57, `table_out`=0x5B, `match`=1.

Source files
------------

// File: rtl/truth_table_probe_if.sv
// Handshake/bus bundle between the truth-table probe and its bench side.
// slave = probe, master = bench driving start/expected and the gate output.
interface truth_table_probe_if;
  logic       start;
  logic [7:0] expected;
  logic       probe_out;
  logic [2:0] probe_in;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic       match;

  modport master (
    output start, expected, probe_out,
    input  probe_in, busy, done, table_out, match
  );

  modport slave (
    input  start, expected, probe_out,
    output probe_in, busy, done, table_out, match
  );
endinterface

// File: rtl/truth_table_probe.sv
// Steps a 3-input gate through all 8 vectors and assembles its truth table.
// Optional TRUTH_PROBE_SYNC_EN adds a 2-flop synchronizer on probe_out.
module truth_table_probe #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  truth_table_probe_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_e;

`ifdef TRUTH_PROBE_SYNC_EN
  localparam int unsigned DriveLen = SETTLE_CYCLES + 2;
`else
  localparam int unsigned DriveLen = SETTLE_CYCLES;
`endif
  localparam logic [8:0] LastCnt = 9'(DriveLen - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] table_q, table_d;
  logic       match_q, match_d;
  logic       sample_bit;

`ifdef TRUTH_PROBE_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.probe_out;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sample_bit = sync2_q;
`else
  assign sample_bit = bus.probe_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      table_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      table_q <= table_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (bus.start) state_d = DRIVE;
      DRIVE:  if (cnt_q == LastCnt) state_d = SAMPLE;
      SAMPLE: state_d = (idx_q == 3'd7) ? DONE : DRIVE;
      DONE:   state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    table_d = table_q;
    match_d = match_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d   = '0;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      DRIVE: cnt_d = cnt_q + 9'd1;
      SAMPLE: begin
        // vector 000 lands in the MSB
        shift_d[3'd7 - idx_q] = sample_bit;
        cnt_d = '0;
        if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
      end
      DONE: begin
        table_d = shift_q;
        match_d = (shift_q == bus.expected);
      end
    endcase
  end

  // Results are visible during the done cycle and then held by the flops.
  always_comb begin
    bus.probe_in  = idx_q;
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.table_out = (state_q == DONE) ? shift_q : table_q;
    bus.match     = (state_q == DONE) ? (shift_q == bus.expected)
                                      : match_q;
  end

endmodule

// File: tb/tb_truth_table_probe.sv
// Scoreboard bench for truth_table_probe: random gate functions,
// queued expectations, independent monitors on done.
module tb_truth_table_probe;

  localparam int S = 4;
`ifdef TRUTH_PROBE_SYNC_EN
  localparam int D = S + 2;
`else
  localparam int D = S;
`endif
  localparam int LAT = 8 * (D + 1) + 1;

  typedef struct {
    logic [7:0] tbl;
    logic       m;
    int         c0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] func = 8'h00;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         run_c0 = 0;
  bit         run_on = 1'b0;
  bit         idle_chk = 1'b0;
  exp_t       q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  truth_table_probe_if bus();
  truth_table_probe #(.SETTLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  assign bus.probe_out = func[3'd7 - bus.probe_in];

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int   t;
    exp_t e;
    t = cyc - run_c0;
    if (run_on && t >= 1 && t <= LAT) begin
      chk("busy_run", bus.busy, 1);
      if (t <= 8 * (D + 1)) chk("probe_in", bus.probe_in, (t - 1) / (D + 1));
      else chk("probe_in_done", bus.probe_in, 7);
    end
    if (bus.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("table_out", bus.table_out, e.tbl);
        chk("match", bus.match, e.m);
        chk("done_latency", cyc - e.c0, LAT);
      end
      run_on = 1'b0;
      idle_chk = 1'b1;
    end else if (idle_chk) begin
      chk("busy_after_done", bus.busy, 0);
      idle_chk = 1'b0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("idle_timeout", 0, 1);
  endtask

  task automatic run(input logic [7:0] f, input logic [7:0] ex,
                     input bit push);
    exp_t e;
    wait_idle();
    func = f;
    bus.expected = ex;
    bus.start = 1'b1;
    run_c0 = cyc;
    run_on = 1'b1;
    if (push) begin
      e.tbl = f;
      e.m = (f == ex);
      e.c0 = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

`ifndef TRUTH_PROBE_SYNC_EN
  logic [7:0] slow_f = 8'h5B;
  logic [2:0] p_last = 3'd0;
  logic       d1 = 1'b0;
  logic       d2 = 1'b0;
  logic       d3 = 1'b0;
  exp_t       q2[$];

  truth_table_probe_if bus2();
  truth_table_probe #(.SETTLE_CYCLES(2)) u_slow (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  // gate whose output lags its inputs by three cycles
  always @(posedge clk) begin
    d1 <= slow_f[3'd7 - bus2.probe_in];
    d2 <= d1;
    d3 <= d2;
  end
  assign bus2.probe_out = d3;

  function automatic logic [7:0] lagged(input logic [7:0] f,
                                        input logic [2:0] p0);
    logic [7:0] r;
    logic [2:0] pv;
    for (int k = 0; k < 8; k++) begin
      pv = (k == 0) ? p0 : 3'(k - 1);
      r[7 - k] = f[7 - pv];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus2.done) begin
      if (q2.size() == 0) begin
        chk("slow_unexpected_done", 1, 0);
      end else begin
        e = q2.pop_front();
        chk("slow_table_out", bus2.table_out, e.tbl);
        chk("slow_match", bus2.match, e.m);
      end
    end
  end

  task automatic run2();
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (bus2.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    e.tbl = lagged(slow_f, p_last);
    e.m = (e.tbl == bus2.expected);
    e.c0 = cyc;
    q2.push_back(e);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    p_last = 3'd7;
  endtask

  initial begin
    bus2.start = 1'b0;
    bus2.expected = 8'h5B;
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          c0a;
    logic [7:0]  f;
    logic [7:0]  ex;
    bus.start = 1'b0;
    bus.expected = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_probe_in", bus.probe_in, 0);
    chk("rst_table_out", bus.table_out, 0);
    chk("rst_match", bus.match, 0);
    rst = 1'b0;

    run(8'h5B, 8'h5B, 1);
    run(8'h00, 8'h5B, 1);
    run(8'hFF, 8'hFF, 1);

    run(8'h5B, 8'h5B, 1);
    c0a = run_c0;
    while (cyc - c0a < 5) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc - c0a < 30) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    run(8'hA6, 8'hA6, 1);
    chk("restart_gap", run_c0 - c0a, 42);

    run(8'h5B, 8'h5B, 0);
    c0a = run_c0;
    while (cyc - c0a < 20) @(negedge clk);
    rst = 1'b1;
    run_on = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_probe_in", bus.probe_in, 0);
    chk("abort_table_out", bus.table_out, 0);
    chk("abort_match", bus.match, 0);
    run(8'h5B, 8'h5B, 1);

    wait_idle();
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    chk("rst_wins_busy", bus.busy, 0);
    @(negedge clk);
    chk("rst_wins_idle", bus.busy, 0);

    for (int i = 0; i < 10; i++) begin
      f = 8'($urandom);
      ex = ($urandom_range(0, 1) == 1) ? f : 8'($urandom);
      run(f, ex, 1);
    end

`ifndef TRUTH_PROBE_SYNC_EN
    run2();
    run2();
`endif

    for (int n = 0; n < 300 && q.size() > 0; n++) @(negedge clk);
    chk("missing_done", q.size(), 0);
`ifndef TRUTH_PROBE_SYNC_EN
    for (int n = 0; n < 300 && q2.size() > 0; n++) @(negedge clk);
    chk("slow_missing_done", q2.size(), 0);
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
